mem_arbiter: RTL and testbench

- Shares the single system-bus memory port between the instruction-fetch requester (read-only) and the execute-stage data requester (load/store from executrol).
- Sequences one bus transaction at a time with a req/ack handshake and variable slave latency.
- Returns read data and a done pulse to the owner, and generates pipeline stall signals.
- Handles fetch discard on jump, starvation avoidance and bus timeout.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arb_prio.sv | 24 ++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared types and constants for the fetch/data memory-port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_D = 2'd1,
        ST_BUSY_I = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_D = 1'b0,
        OWNER_I = 1'b1
    } owner_e;

    localparam logic [3:0] c_fetch_byte_sel   = 4'b1111;
    localparam int         c_max_d_burst_dflt = 4;
    localparam int         c_timeout_dflt     = 64;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_prio
// Brief  : Combinational grant decision between fetch and data requesters.
// Rev    : 1.0  initial release
// ============================================================================
module mem_arb_prio (
    input  logic i_req,
    input  logic d_req,
    input  logic i_flush,
    input  logic burst_full,
    output logic grant_i,
    output logic grant_d
);

    logic w_fetch_ok;

    // A fetch killed by a jump in this same cycle never reaches the bus.
    assign w_fetch_ok = i_req & ~i_flush;
    assign grant_i    = w_fetch_ok & (burst_full | ~d_req);
    assign grant_d    = d_req & ~grant_i;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares one system-bus memory port between fetch and data requesters.
// Rev    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = c_max_d_burst_dflt,
    parameter int TIMEOUT     = c_timeout_dflt
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_done_o,
    output logic [31:0] i_rdata_o,
    input  logic        i_flush_i,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_byte_sel_i,
    output logic        d_done_o,
    output logic [31:0] d_rdata_o,
    output logic        err_o,
    output logic        hold_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_byte_sel_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int c_burst_w = cnt_width(MAX_D_BURST);
    localparam int c_to_w    = cnt_width(TIMEOUT);
    localparam logic [c_burst_w-1:0] c_burst_max = c_burst_w'(MAX_D_BURST);
    localparam logic [c_to_w-1:0]    c_to_max    = c_to_w'(TIMEOUT);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [c_burst_w-1:0]   r_burst_cnt;
    logic [c_to_w-1:0]      r_to_cnt;
    logic                   r_discard;

    logic                   w_idle;
    logic                   w_busy;
    logic                   w_pri_i;
    logic                   w_pri_d;
    logic                   w_grant_i;
    logic                   w_grant_d;
    owner_e                 w_grant_owner;
    logic                   w_timeout;
    logic                   w_end;
    logic [31:0]            w_rdata;

    assign w_idle = (r_state == ST_IDLE);
    assign w_busy = ~w_idle;

    mem_arb_prio u_prio (
        .i_req      (i_req_i),
        .d_req      (d_req_i),
        .i_flush    (i_flush_i),
        .burst_full (r_burst_cnt == c_burst_max),
        .grant_i    (w_pri_i),
        .grant_d    (w_pri_d)
    );

    assign w_grant_i     = w_idle & w_pri_i;
    assign w_grant_d     = w_idle & w_pri_d;
    assign w_grant_owner = w_grant_d ? OWNER_D : OWNER_I;

    // A zero TIMEOUT leaves the comparison permanently false.
    assign w_timeout = (TIMEOUT != 0) && (r_to_cnt == c_to_max);
    assign w_end     = w_busy & (mem_ack_i | w_timeout);
    assign w_rdata   = mem_ack_i ? mem_rdata_i : 32'd0;

    assign d_done_o  = w_end & (r_state == ST_BUSY_D);
    assign i_done_o  = w_end & (r_state == ST_BUSY_I) & ~r_discard & ~i_flush_i;
    assign d_rdata_o = d_done_o ? w_rdata : 32'd0;
    assign i_rdata_o = i_done_o ? w_rdata : 32'd0;
    assign err_o     = w_end & ~mem_ack_i & (d_done_o | i_done_o);
    assign hold_o    = (d_req_i & ~d_done_o) | (i_req_i & ~i_done_o);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = ST_BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_D, ST_BUSY_I: begin
                if (w_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_burst_cnt    <= '0;
            r_to_cnt       <= '0;
            r_discard      <= 1'b0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= 32'd0;
            mem_wdata_o    <= 32'd0;
            mem_byte_sel_o <= 4'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_d || w_grant_i) begin
                mem_req_o <= 1'b1;
                if (w_grant_owner == OWNER_D) begin
                    mem_we_o       <= d_we_i;
                    mem_addr_o     <= d_addr_i;
                    mem_wdata_o    <= d_wdata_i;
                    mem_byte_sel_o <= d_byte_sel_i;
                end else begin
                    mem_we_o       <= 1'b0;
                    mem_addr_o     <= i_addr_i;
                    mem_wdata_o    <= 32'd0;
                    mem_byte_sel_o <= c_fetch_byte_sel;
                end
            end else if (w_end) begin
                mem_req_o <= 1'b0;
            end

            // Counts data wins that skipped a waiting fetch.
            if (w_grant_i || (w_grant_d && !i_req_i)) begin
                r_burst_cnt <= '0;
            end else if (w_grant_d && (r_burst_cnt != c_burst_max)) begin
                r_burst_cnt <= r_burst_cnt + c_burst_w'(1);
            end

            if (w_busy && !w_end) begin
                r_to_cnt <= r_to_cnt + c_to_w'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if (w_end) begin
                r_discard <= 1'b0;
            end else if ((r_state == ST_BUSY_I) && i_flush_i) begin
                r_discard <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Directed and randomized checks of mem_arbiter against a cycle model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_maxb = 4;
    localparam int c_tout = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_i, i_flush_i, d_req_i, d_we_i, mem_ack_i;
    logic [31:0] i_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
    logic [3:0]  d_byte_sel_i;
    wire         i_done_o, d_done_o, err_o, hold_o, mem_req_o, mem_we_o;
    wire  [31:0] i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
    wire  [3:0]  mem_byte_sel_o;

    mem_arbiter #(.MAX_D_BURST(c_maxb), .TIMEOUT(c_tout)) dut (
        .clk(clk), .rst(rst),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_done_o(i_done_o), .i_rdata_o(i_rdata_o),
        .i_flush_i(i_flush_i),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_byte_sel_i(d_byte_sel_i), .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
        .err_o(err_o), .hold_o(hold_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_byte_sel_o(mem_byte_sel_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bus transaction in flight and its bookkeeping.
    bit          m_busy, m_own_i, m_we, m_disc;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_bsel;
    int          m_wait, m_streak, s_lat;
    int          lat_ovr = -1;
    bit          rdata_fix = 1'b0, spur_en = 1'b0;
    logic [31:0] fix_val = 32'd0;
    bit          last_i_done, last_d_done, last_flush;
    int          cyc = 0, dut_i_cnt = 0, dut_d_cnt = 0, dut_err_cnt = 0;
    int          i_done_cyc, d_done_cyc;
    logic [31:0] i_done_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_lat();
        if (lat_ovr >= 0) return lat_ovr;
        if ($urandom_range(0, 15) == 0) return 1000;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic slave_drive();
        if (m_busy) mem_ack_i = (m_wait >= s_lat);
        else        mem_ack_i = spur_en && ($urandom_range(0, 7) == 0);
        mem_rdata_i = rdata_fix ? fix_val : $urandom;
    endtask

    // Checks this cycle's outputs, advances the model, moves to the next cycle.
    task automatic eval();
        bit          e_to, e_end, e_i, e_d, e_err, fetch_ok;
        logic [31:0] e_rd;
        #1;
        e_to  = m_busy && (m_wait == c_tout);
        e_end = m_busy && (mem_ack_i || e_to);
        e_d   = e_end && !m_own_i;
        e_i   = e_end && m_own_i && !m_disc && !i_flush_i;
        e_err = e_end && !mem_ack_i && (e_d || e_i);
        e_rd  = mem_ack_i ? mem_rdata_i : 32'd0;

        chk("mem_req", mem_req_o, m_busy);
        if (m_busy) begin
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_we", mem_we_o, m_we);
            chk("mem_bsel", mem_byte_sel_o, m_bsel);
            if (!m_own_i) chk("mem_wdata", mem_wdata_o, m_wdata);
        end
        chk("d_done", d_done_o, e_d);
        chk("i_done", i_done_o, e_i);
        chk("err", err_o, e_err);
        if (e_d) chk("d_rdata", d_rdata_o, e_rd);
        if (e_i) chk("i_rdata", i_rdata_o, e_rd);
        chk("hold", hold_o, (d_req_i && !e_d) || (i_req_i && !e_i));

        if (i_done_o === 1'b1) begin dut_i_cnt++; i_done_cyc = cyc; i_done_addr = i_addr_i; end
        if (d_done_o === 1'b1) begin dut_d_cnt++; d_done_cyc = cyc; end
        if (err_o === 1'b1) dut_err_cnt++;

        last_i_done = e_i;
        last_d_done = e_d;
        last_flush  = i_flush_i;
        if (rst) begin
            m_busy = 1'b0; m_streak = 0; m_disc = 1'b0;
        end else if (m_busy) begin
            if (m_own_i && i_flush_i) m_disc = 1'b1;
            if (e_end) begin m_busy = 1'b0; m_disc = 1'b0; end
            else m_wait++;
        end else begin
            fetch_ok = i_req_i && !i_flush_i;
            if (fetch_ok && (m_streak == c_maxb || !d_req_i)) begin
                m_busy = 1'b1; m_own_i = 1'b1; m_streak = 0;
                m_addr = i_addr_i; m_we = 1'b0; m_bsel = 4'b1111; m_wdata = 32'd0;
            end else if (d_req_i) begin
                m_busy = 1'b1; m_own_i = 1'b0;
                m_streak = i_req_i ? ((m_streak < c_maxb) ? m_streak + 1 : c_maxb) : 0;
                m_addr = d_addr_i; m_we = d_we_i; m_bsel = d_byte_sel_i; m_wdata = d_wdata_i;
            end
            if (m_busy) begin m_wait = 0; m_disc = 1'b0; s_lat = pick_lat(); end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        i_req_i = 1'b0; d_req_i = 1'b0; i_flush_i = 1'b0;
        for (int k = 0; k < n; k++) begin slave_drive(); eval(); end
    endtask

    task automatic rand_reqs();
        if (!d_req_i || last_d_done) begin
            d_req_i      = ($urandom_range(0, 3) != 0);
            d_we_i       = 1'($urandom_range(0, 1));
            d_addr_i     = $urandom;
            d_wdata_i    = $urandom;
            d_byte_sel_i = 4'($urandom_range(1, 15));
        end
        if (!i_req_i || last_i_done || last_flush) begin
            i_req_i  = ($urandom_range(0, 3) != 0);
            i_addr_i = $urandom;
        end
        i_flush_i = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        int base_d, base_i, base_e;
        rst = 1'b1; i_req_i = 0; i_flush_i = 0; d_req_i = 0; d_we_i = 0; mem_ack_i = 0;
        i_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; mem_rdata_i = 0; d_byte_sel_i = 0;
        m_busy = 0; m_streak = 0; m_disc = 0; m_wait = 0;
        last_i_done = 0; last_d_done = 0; last_flush = 0;
        repeat (2) @(posedge clk);
        #1;
        eval();
        rst = 1'b0;

        // Single fetch, ack two cycles after the request rises.
        lat_ovr = 2; rdata_fix = 1'b1; fix_val = 32'h0010_0093;
        i_req_i = 1'b1; i_addr_i = 32'h100;
        for (int k = 0; k < 8; k++) begin
            if (last_i_done) i_req_i = 1'b0;
            slave_drive(); eval();
        end
        chk("t1_i_done_count", dut_i_cnt, 1);
        rdata_fix = 1'b0;

        // Store and fetch together: the store goes first.
        lat_ovr = 1; base_d = dut_d_cnt; base_i = dut_i_cnt;
        i_req_i = 1'b1; i_addr_i = 32'h180;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'hAB; d_byte_sel_i = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            if (last_i_done) i_req_i = 1'b0;
            if (last_d_done) d_req_i = 1'b0;
            slave_drive(); eval();
        end
        chk("t2_done_counts", {dut_d_cnt - base_d, dut_i_cnt - base_i}, {32'd1, 32'd1});
        chk("t2_store_first", (d_done_cyc < i_done_cyc), 1);
        idle_cycles(2);

        // Back-to-back data with a waiting fetch: exactly MAX_D_BURST data wins.
        lat_ovr = 0; base_d = dut_d_cnt; base_i = dut_i_cnt;
        i_req_i = 1'b1; i_addr_i = 32'h400; d_req_i = 1'b1; d_we_i = 1'b0;
        for (int k = 0; k < 40 && dut_i_cnt == base_i; k++) begin
            if (last_d_done) d_addr_i = d_addr_i + 32'd4;
            slave_drive(); eval();
        end
        chk("t3_data_before_fetch", dut_d_cnt - base_d, c_maxb);
        idle_cycles(3);

        // Flush during a fetch: first fetch discarded, redirected fetch completes.
        lat_ovr = 3; base_i = dut_i_cnt;
        i_req_i = 1'b1; i_addr_i = 32'h280;
        for (int k = 0; k < 25 && dut_i_cnt == base_i; k++) begin
            i_flush_i = (k == 2);
            if (last_flush) i_addr_i = 32'h300;
            slave_drive(); eval();
        end
        chk("t4_i_done_count", dut_i_cnt - base_i, 1);
        chk("t4_done_addr", i_done_addr, 32'h300);
        idle_cycles(2);

        // Load with no ack ends by timeout.
        lat_ovr = 1000; base_d = dut_d_cnt; base_e = dut_err_cnt;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500;
        for (int k = 0; k < 14; k++) begin
            if (last_d_done) d_req_i = 1'b0;
            slave_drive(); eval();
        end
        chk("t5_timeout_done", dut_d_cnt - base_d, 1);
        chk("t5_err_count", dut_err_cnt - base_e, 1);

        // Reset while a store is on the bus; a late ack must be ignored.
        base_d = dut_d_cnt;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h600; d_wdata_i = 32'h55;
        for (int k = 0; k < 4; k++) begin slave_drive(); eval(); end
        rst = 1'b1; mem_ack_i = 1'b0; eval();
        rst = 1'b0; d_req_i = 1'b0; mem_ack_i = 1'b1; eval();
        mem_ack_i = 1'b0; eval();
        chk("t6_no_done_after_rst", dut_d_cnt - base_d, 0);

        // Randomized traffic, spurious acks, flushes and occasional timeouts.
        lat_ovr = -1; spur_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            rand_reqs(); slave_drive(); eval();
        end
        spur_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (last_i_done || last_flush) i_req_i = 1'b0;
            if (last_d_done) d_req_i = 1'b0;
            i_flush_i = 1'b0;
            slave_drive(); eval();
        end
        chk("drain_idle", {31'd0, m_busy}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
